// File: rtl/pwm_capture_pkg.sv
// Shared types and default widths for the PWM input capture block.
package pwm_capture_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int DIVCLK_WIDTH   = 5;
    localparam int INTCOUNT_WIDTH = 3;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;
    typedef enum logic {INT_OFF = 1'b0, INT_ON = 1'b1} _int_onoff;
    typedef enum logic {CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1} _clkdiv_onoff;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ARM  = 2'd1,
        CAP_HIGH = 2'd2,
        CAP_LOW  = 2'd3
    } _cap_state;

endpackage

// File: rtl/pwm_cap_sync.sv
// Synchronizes the asynchronous PWM input and produces registered single-clk
// rise/fall strobes.
module pwm_cap_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            last_q <= level;
            rise   <= level & ~last_q;
            fall   <= ~level & last_q;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in prescaled ticks
// and publishes each completed measurement with a valid strobe and decimated irq.
//
// state    | meaning
// CAP_IDLE | capture disabled, counters held at zero
// CAP_ARM  | waiting for a first rise to start a clean measurement
// CAP_HIGH | input high, counting high time
// CAP_LOW  | input low, counting rest of period until next rise
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH   = PWMCOUNT_WIDTH,
    parameter int DIV_WIDTH   = DIVCLK_WIDTH,
    parameter int INT_WIDTH   = INTCOUNT_WIDTH,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  _pwm_onoff            enable,
    input  _clkdiv_onoff         clkdiv_en,
    input  logic [DIV_WIDTH-1:0] clkdiv,
    input  _int_onoff            int_en,
    input  logic [INT_WIDTH-1:0] int_period,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 overflow_o,
    output logic                 int_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [INT_WIDTH-1:0] INT_ONE = INT_WIDTH'(1);

    _cap_state            state, state_nxt;
    logic                 rise, fall;
    logic [DIV_WIDTH-1:0] presc;
    logic                 tick;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cap_val;
    logic [CNT_WIDTH-1:0] high_cap;
    logic [INT_WIDTH-1:0] dec;
    logic                 ovf_tick;
    logic                 run;
    logic                 cnt_clr;
    logic                 cap_high;
    logic                 cap_period;
    logic                 set_ovf;
    logic                 active;

    pwm_cap_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign active   = (enable == PWM_ON) && (state != CAP_IDLE);
    assign tick     = (clkdiv_en == CLKDIV_OFF) || (presc == clkdiv);
    assign ovf_tick = tick && (cnt == '1);
    // The event cycle itself is counted; saturate so an event on the overflow tick reads all-ones.
    assign cap_val  = (cnt == '1) ? cnt : cnt + (tick ? CNT_ONE : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (enable == PWM_OFF) begin
            state_nxt = CAP_IDLE;
        end else begin
            unique case (state)
                CAP_IDLE: state_nxt = CAP_ARM;
                CAP_ARM:  if (rise) state_nxt = CAP_HIGH;
                CAP_HIGH: begin
                    if (fall)          state_nxt = CAP_LOW;
                    else if (ovf_tick) state_nxt = CAP_ARM;
                end
                CAP_LOW: begin
                    if (rise)          state_nxt = CAP_HIGH;
                    else if (ovf_tick) state_nxt = CAP_ARM;
                end
                default: state_nxt = CAP_IDLE;
            endcase
        end
    end

    always_comb begin
        run        = 1'b0;
        cnt_clr    = 1'b0;
        cap_high   = 1'b0;
        cap_period = 1'b0;
        set_ovf    = 1'b0;
        if (enable == PWM_ON) begin
            unique case (state)
                CAP_IDLE: ;
                CAP_ARM:  cnt_clr = rise;
                CAP_HIGH: begin
                    run = 1'b1;
                    if (fall)          cap_high = 1'b1;
                    else if (ovf_tick) set_ovf  = 1'b1;
                end
                CAP_LOW: begin
                    run = 1'b1;
                    if (rise) begin
                        cap_period = 1'b1;
                        cnt_clr    = 1'b1;
                    end else if (ovf_tick) begin
                        set_ovf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Prescaler restarts on every rise so each measurement starts phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (!active || clkdiv_en == CLKDIV_OFF || rise || presc == clkdiv) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || cnt_clr || set_ovf) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cap   <= '0;
            period_o   <= '0;
            high_o     <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            int_o      <= 1'b0;
        end else begin
            valid_o <= cap_period;
            int_o   <= cap_period && (int_en == INT_ON) && (dec == int_period);
            if (cap_high) begin
                high_cap <= cap_val;
            end
            if (enable == PWM_OFF) begin
                overflow_o <= 1'b0;
            end else if (cap_period) begin
                period_o   <= cap_val;
                high_o     <= high_cap;
                overflow_o <= 1'b0;
            end else if (set_ovf) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec <= '0;
        end else if (!active || int_en == INT_OFF) begin
            dec <= '0;
        end else if (cap_period) begin
            dec <= (dec == int_period) ? '0 : dec + INT_ONE;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a 16-bit instance for the main tests and an
// 8-bit instance for the counter-overflow scenario.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    typedef struct {
        int per;
        int hi;
        bit intr;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    _pwm_onoff    enable = PWM_OFF;
    _clkdiv_onoff clkdiv_en = CLKDIV_OFF;
    logic [4:0]   clkdiv = '0;
    _int_onoff    int_en = INT_OFF;
    logic [2:0]   int_period = '0;
    logic         pwm16 = 1'b0;
    logic         pwm8  = 1'b0;

    logic [15:0] per16, hi16;
    logic        valid16, ovf16, int16;
    logic [7:0]  per8, hi8;
    logic        valid8, ovf8, int8;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_valid16 = 0, n_valid8 = 0, n_int16 = 0;
    int   base_v, base_i;
    bit   armed [2];
    int   last_rise [2];
    int   last_fall [2];
    int   dec [2];
    exp_t q0[$], q1[$];

    pwm_capture #(.CNT_WIDTH(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk(clk), .rst(rst), .enable(enable), .clkdiv_en(clkdiv_en), .clkdiv(clkdiv),
        .int_en(int_en), .int_period(int_period), .pwm_in(pwm16),
        .period_o(per16), .high_o(hi16), .valid_o(valid16), .overflow_o(ovf16), .int_o(int16)
    );

    pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .clkdiv_en(clkdiv_en), .clkdiv(clkdiv),
        .int_en(int_en), .int_period(int_period), .pwm_in(pwm8),
        .period_o(per8), .high_o(hi8), .valid_o(valid8), .overflow_o(ovf8), .int_o(int8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ticks(input int c);
        if (clkdiv_en == CLKDIV_ON) return c / (int'(clkdiv) + 1);
        return c;
    endfunction

    function automatic int sat(input int n, input int lim);
        return (n >= lim) ? lim - 1 : n;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            armed[k] = 1'b0;
            dec[k]   = 0;
        end
    endtask

    task automatic set_pwm(input int k, input logic v);
        if (k == 0) pwm16 = v;
        else        pwm8  = v;
    endtask

    // A rise completes the measurement started by the previous armed rise,
    // unless the counter would have passed all-ones first.
    task automatic do_rise(input int k);
        int   np, nh, lim;
        exp_t e;
        lim = (k == 0) ? 65536 : 256;
        if (armed[k]) begin
            np = ticks(cyc - last_rise[k]);
            nh = ticks(last_fall[k] - last_rise[k]);
            if (np <= lim && nh <= lim) begin
                e.per = sat(np, lim);
                e.hi  = sat(nh, lim);
                e.cyc = cyc + LAT;
                if (int_en == INT_ON) begin
                    if (dec[k] == int'(int_period)) begin
                        e.intr = 1'b1;
                        dec[k] = 0;
                    end else begin
                        e.intr = 1'b0;
                        dec[k]++;
                    end
                end else begin
                    e.intr = 1'b0;
                    dec[k] = 0;
                end
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        armed[k]     = 1'b1;
        last_rise[k] = cyc;
    endtask

    task automatic pulse(input int k, input int h, input int p);
        set_pwm(k, 1'b1);
        do_rise(k);
        step(h);
        set_pwm(k, 1'b0);
        last_fall[k] = cyc;
        step(p - h);
    endtask

    task automatic restart(input bit div_on, input int d);
        enable = PWM_OFF;
        step(6);
        if (div_on) clkdiv_en = CLKDIV_ON;
        else        clkdiv_en = CLKDIV_OFF;
        clkdiv = 5'(d);
        clear_model();
        enable = PWM_ON;
        step(6);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (valid16) begin
                n_valid16++;
                chk("valid16_expected", q0.size() != 0, 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("period16", per16, e.per);
                    chk("high16", hi16, e.hi);
                    chk("int16", int16, e.intr);
                    chk("ovf16_on_valid", ovf16, 0);
                    chk("latency16", cyc, e.cyc);
                end
            end
            if (int16) begin
                n_int16++;
                chk("int16_needs_valid", valid16, 1);
            end
            if (valid8) begin
                n_valid8++;
                chk("valid8_expected", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("period8", per8, e.per);
                    chk("high8", hi8, e.hi);
                    chk("ovf8_on_valid", ovf8, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        step(3);
        chk("rst_period", per16, 0);
        chk("rst_high", hi16, 0);
        chk("rst_valid", valid16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_int", int16, 0);
        rst = 1'b0;
        step(3);

        // divider off, H=30 P=100
        restart(1'b0, 0);
        base_v = n_valid16;
        for (int i = 0; i < 6; i++) pulse(0, 30, 100);
        chk("t1_valids", n_valid16 - base_v, 5);
        chk("t1_ovf", ovf16, 0);

        // divider on, clkdiv=3, H=40 P=200 -> 10/50
        restart(1'b1, 3);
        base_v = n_valid16;
        for (int i = 0; i < 4; i++) pulse(0, 40, 200);
        chk("t2_valids", n_valid16 - base_v, 3);
        chk("t2_period", per16, 50);
        chk("t2_high", hi16, 10);

        // interrupt decimation every third valid, then interrupts off
        int_en = INT_ON;
        int_period = 3'd2;
        restart(1'b0, 0);
        base_v = n_valid16;
        base_i = n_int16;
        for (int i = 0; i < 10; i++) pulse(0, 20, 64);
        chk("t3_valids", n_valid16 - base_v, 9);
        chk("t3_ints", n_int16 - base_i, 3);
        int_en = INT_OFF;
        base_i = n_int16;
        for (int i = 0; i < 4; i++) pulse(0, 20, 64);
        chk("t3_ints_off", n_int16 - base_i, 0);

        // disable while high, then re-enable
        set_pwm(0, 1'b1);
        do_rise(0);
        step(10);
        enable = PWM_OFF;
        clear_model();
        step(10);
        chk("t4_hold_period", per16, 64);
        chk("t4_hold_high", hi16, 20);
        chk("t4_ovf_cleared", ovf16, 0);
        set_pwm(0, 1'b0);
        step(30);
        enable = PWM_ON;
        step(6);
        base_v = n_valid16;
        pulse(0, 30, 100);
        chk("t4_one_rise_no_valid", n_valid16 - base_v, 0);
        pulse(0, 30, 100);
        pulse(0, 30, 100);
        chk("t4_valids", n_valid16 - base_v, 2);

        // async reset in the low phase
        set_pwm(0, 1'b1);
        do_rise(0);
        step(30);
        set_pwm(0, 1'b0);
        last_fall[0] = cyc;
        step(20);
        chk("t5_pre_period", per16, 100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_period", per16, 0);
        chk("t5_async_high", hi16, 0);
        chk("t5_async_valid", valid16, 0);
        chk("t5_async_ovf", ovf16, 0);
        chk("t5_async_int", int16, 0);
        clear_model();
        step(3);
        rst = 1'b0;
        step(5);
        base_v = n_valid16;
        pulse(0, 30, 100);
        chk("t5_one_rise_no_valid", n_valid16 - base_v, 0);
        pulse(0, 30, 100);
        pulse(0, 30, 100);
        chk("t5_valids", n_valid16 - base_v, 2);

        // 8-bit counter stuck high overflows, then recovers
        restart(1'b0, 0);
        base_v = n_valid8;
        set_pwm(1, 1'b1);
        do_rise(1);
        step(400);
        chk("t6_ovf_set", ovf8, 1);
        chk("t6_no_valid", n_valid8 - base_v, 0);
        set_pwm(1, 1'b0);
        last_fall[1] = cyc;
        step(20);
        pulse(1, 10, 50);
        chk("t6_arm_no_valid", n_valid8 - base_v, 0);
        chk("t6_ovf_held", ovf8, 1);
        pulse(1, 10, 50);
        chk("t6_valid", n_valid8 - base_v, 1);
        chk("t6_ovf_clear", ovf8, 0);
        chk("t6_period", per8, 50);
        chk("t6_high", hi8, 10);

        step(20);
        chk("q16_drained", q0.size(), 0);
        chk("q8_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
